instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Encodes instruction fields into 32-bit MIPS instruction words and writes them sequentially into instruction memory.
- Acts as the program-loading front end for the datapath, the encoding counterpart of the main control decoder.
- Accepts only the opcode set the control unit supports: R-format, LW, LWC1, SW, BEQ, ADDI, SLTI, ANDI, ORI.
- Rejects illegal opcodes, counts them, and captures the first offending opcode.

Parameters:
ADDR_W, 8, word-index width of instruction memory
DEPTH, 256, number of writable words (must be <= 2**ADDR_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  pulse; opens a load session
base_idx  in  ADDR_W  first word index, sampled on accepted start
in_valid  in  1  instruction fields valid
in_ready  out  1  block can accept fields
in_last  in  1  marks final instruction of the session
op  in  6  opcode
rs  in  5  source register
rt  in  5  target register
rd  in  5  destination register (R only)
shamt  in  5  shift amount (R only)
funct  in  6  function code (R only)
imm  in  16  immediate / branch offset (I only)
mem_we  out  1  instruction-memory write strobe
mem_addr  out  ADDR_W+2  byte address = word index * 4
mem_wdata  out  32  encoded word
busy  out  1  high in ACCEPT or WRITE
done  out  1  one-cycle pulse at session end
full  out  1  memory end reached
err_flag  out  1  sticky illegal-opcode flag
err_op  out  6  first illegal opcode of session
word_count  out  ADDR_W+1  words written this session
err_count  out  8  illegal instructions this session, saturates at 255

Behaviour:
- Reset (async, any state) forces state IDLE and clears every output and internal register to 0. A write in flight is abandoned; mem_we drops immediately.
- States: IDLE, ACCEPT, WRITE, FULL.
- IDLE:
  - in_ready=0.
  - On start: ptr=base_idx; word_count, err_count, err_flag, err_op and full are cleared; go to ACCEPT.
- ACCEPT:
  - in_ready=1. A handshake is in_valid & in_ready.
  - Legal opcode:
    - R-format encodes as {op,rs,rt,rd,shamt,funct}.
    - Other legal opcodes encode as {op,rs,rt,imm}; rd, shamt and funct are ignored.
    - The encoded word is registered and the state goes to WRITE.
  - Illegal opcode:
    - No write. err_count increments (saturating at 255) and err_flag is set.
    - err_op is loaded only if err_flag was 0.
    - If in_last is set, done pulses and the state goes to IDLE; otherwise it stays in ACCEPT.
  - start is ignored in ACCEPT.
- WRITE (exactly one cycle):
  - in_ready=0, mem_we=1, mem_addr={ptr,2'b00}, mem_wdata=word.
  - ptr and word_count increment.
  - Next state priority:
    - If the written instruction carried in_last: done pulses next cycle and go to IDLE. in_last takes priority over full.
    - Else if ptr == DEPTH-1 or ptr == 2**ADDR_W-1: go to FULL and set full.
    - Else return to ACCEPT.
  - start is ignored in WRITE.
- FULL:
  - in_ready=0, full=1, done pulses on entry.
  - start restarts the session exactly as from IDLE.
- Timing:
  - Handshake at cycle t gives mem_we at t+1.
  - Peak throughput is 1 instruction per 2 cycles.
  - mem_wdata and mem_addr are valid only while mem_we=1; at other times they hold their last value.
- Bit slicing is exact: no sign extension or shifting of imm is applied here. Branch offset semantics belong to the datapath.
- The legal opcode set is exactly: 000000, 100011, 110001, 101011, 000100, 001000, 001010, 001100, 001101.

Test Plan:
- R-format: start, base_idx=0; send op=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0x00221820; word_count=1.
- I-type: send LW op=0x23, rs=16, rt=8, imm=4 -> mem_wdata=0x8E080004. Then ADDI op=0x08, rs=1, rt=2, imm=0xFFFF with in_last -> mem_wdata=0x2022FFFF at mem_addr=4; done pulses; state IDLE; in_ready=0.
- Illegal opcodes: send op=0x02, then op=0x03 -> no mem_we; err_flag=1, err_op=0x02, err_count=2. A following legal BEQ op=0x04, rs=1, rt=2, imm=0x0003 writes 0x10220003.
- Fill: DEPTH=4, base_idx=0; send 5 legal instructions -> 4 writes at addresses 0, 4, 8, 12; full=1; done pulse; in_ready=0 for the 5th. A new start clears full and reopens ACCEPT.
- Mid-write reset: assert rst during the WRITE cycle -> mem_we falls immediately; all outputs are 0 and state is IDLE after release. start in ACCEPT is ignored: ptr unchanged.
- Saturation: 300 illegal instructions -> err_count=255; err_op holds the first opcode.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes MIPS instruction fields into 32-bit words and writes them sequentially
// into instruction memory. Illegal opcodes are counted and the first one is captured.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_idx,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W+1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err_flag,
  output logic [5:0]        err_op,
  output logic [ADDR_W:0]   word_count,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    FULL   = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] widx;
  logic              last_q;
  logic              legal;
  logic              at_end;
  logic [31:0]       enc;

  always_comb begin
    legal = 1'b0;
    case (op)
      6'b000000, 6'b100011, 6'b110001, 6'b101011, 6'b000100,
      6'b001000, 6'b001010, 6'b001100, 6'b001101: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    enc = (op == 6'b000000) ? {op, rs, rt, rd, shamt, funct} : {op, rs, rt, imm};
  end

  // The word index being written is recovered from the registered byte address.
  assign widx     = mem_addr[ADDR_W+1:2];
  assign at_end   = (widx == LAST_IDX) || (widx == {ADDR_W{1'b1}});
  assign in_ready = (state == ACCEPT);
  assign busy     = (state == ACCEPT) || (state == WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      last_q     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      full       <= 1'b0;
      err_flag   <= 1'b0;
      err_op     <= '0;
      word_count <= '0;
      err_count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FULL: begin
          if (start) begin
            ptr        <= base_idx;
            last_q     <= 1'b0;
            word_count <= '0;
            err_count  <= '0;
            err_flag   <= 1'b0;
            err_op     <= '0;
            full       <= 1'b0;
            state      <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            if (legal) begin
              mem_we     <= 1'b1;
              mem_addr   <= {ptr, 2'b00};
              mem_wdata  <= enc;
              ptr        <= ptr + 1'b1;
              word_count <= word_count + 1'b1;
              last_q     <= in_last;
              state      <= WRITE;
            end else begin
              if (err_count != 8'hFF) err_count <= err_count + 1'b1;
              if (!err_flag) err_op <= op;
              err_flag <= 1'b1;
              if (in_last) begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end
          end
        end
        WRITE: begin
          mem_we <= 1'b0;
          // A final instruction ends the session even when it also hits the end of memory.
          if (last_q) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (at_end) begin
            full  <= 1'b1;
            done  <= 1'b1;
            state <= FULL;
          end else begin
            state <= ACCEPT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized bench for instr_encoder: a reference model predicts every
// memory write and status value; a second instance with DEPTH=4 covers the fill path.
module tb_instr_encoder;
  localparam int ADDR_W = 8;
  localparam int W      = 42;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              start2 = 1'b0;
  logic [ADDR_W-1:0] base_idx = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic [5:0]        op = '0;
  logic [4:0]        rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]        funct = '0;
  logic [15:0]       imm = '0;

  logic              in_ready, mem_we, busy, done, full, err_flag;
  logic [ADDR_W+1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [5:0]        err_op;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        err_count;

  logic              in_ready2, mem_we2, busy2, done2, full2, err_flag2;
  logic [ADDR_W+1:0] mem_addr2;
  logic [31:0]       mem_wdata2;
  logic [5:0]        err_op2;
  logic [ADDR_W:0]   word_count2;
  logic [7:0]        err_count2;

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int done2_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] exp2_q[$];
  logic [W-1:0] obs2_q[$];

  int         m_ptr, m_wc, m_ec;
  logic       m_ef;
  logic [5:0] m_eo;
  logic [5:0] legal_ops[9] = '{6'h00, 6'h23, 6'h31, 6'h2B, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D};

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .base_idx(base_idx),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .full(full), .err_flag(err_flag), .err_op(err_op),
    .word_count(word_count), .err_count(err_count)
  );

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start2), .base_idx(base_idx),
    .in_valid(in_valid), .in_ready(in_ready2), .in_last(in_last),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .busy(busy2), .done(done2), .full(full2), .err_flag(err_flag2), .err_op(err_op2),
    .word_count(word_count2), .err_count(err_count2)
  );

  always @(negedge clk) begin
    if (mem_we) obs_q.push_back({mem_addr, mem_wdata});
    if (mem_we2) obs2_q.push_back({mem_addr2, mem_wdata2});
    if (done) done_cnt++;
    if (done2) done2_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_word(input logic [5:0] o, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] im);
    logic [31:0] w;
    w = (32'(o) << 26) | (32'(s) << 21) | (32'(t) << 16);
    if (o == 6'd0) w = w | (32'(d) << 11) | (32'(sh) << 6) | 32'(fn);
    else w = w | 32'(im);
    return w;
  endfunction

  task automatic m_start(input int b);
    m_ptr = b; m_wc = 0; m_ec = 0; m_ef = 1'b0; m_eo = '0;
  endtask

  task automatic start_pulse(input bit sel, input logic [ADDR_W-1:0] b);
    @(negedge clk);
    base_idx = b;
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start2 = 1'b0;
  endtask

  // Presents one instruction and waits (bounded) for the handshake; returns at posedge+1.
  task automatic send(input bit sel, input logic [5:0] o, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] im, input logic l, output bit ok);
    @(negedge clk);
    op = o; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im;
    in_last = l; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sel ? in_ready2 : in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_m(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
      input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] im, input logic l);
    bit ok;
    send(1'b0, o, s, t, d, sh, fn, im, l, ok);
    chk("handshake", 64'(ok), 64'd1);
    if (is_legal(o)) begin
      exp_q.push_back({10'(m_ptr * 4), model_word(o, s, t, d, sh, fn, im)});
      m_ptr++;
      m_wc++;
    end else begin
      if (!m_ef) m_eo = o;
      m_ef = 1'b1;
      m_ec = (m_ec < 255) ? m_ec + 1 : 255;
    end
  endtask

  task automatic check_writes(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, "_write"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic session_end(input string tag, input int d0);
    check_writes(tag);
    chk({tag, "_done"}, 64'(done_cnt), 64'(d0 + 1));
    chk({tag, "_wcount"}, 64'(word_count), 64'(m_wc));
    chk({tag, "_ecount"}, 64'(err_count), 64'(m_ec));
    chk({tag, "_eflag"}, 64'(err_flag), 64'(m_ef));
    chk({tag, "_eop"}, 64'(err_op), 64'(m_eo));
    chk({tag, "_ready_idle"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    int d0;
    bit ok;
    logic [5:0] o;
    logic [4:0] s, t;
    logic [15:0] im;

    // Reset state
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_wcount", 64'(word_count), 64'd0);
    chk("rst_ecount", 64'(err_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // R-format single-word session
    d0 = done_cnt;
    start_pulse(1'b0, 8'd0);
    m_start(0);
    chk("r_ready", 64'(in_ready), 64'd1);
    chk("r_busy", 64'(busy), 64'd1);
    send_m(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 1'b1);
    chk("r_we", 64'(mem_we), 64'd1);
    chk("r_addr", 64'(mem_addr), 64'd0);
    chk("r_wdata", 64'(mem_wdata), 64'h00221820);
    chk("r_wcount", 64'(word_count), 64'd1);
    session_end("r", d0);

    // LW then ADDI with in_last
    d0 = done_cnt;
    start_pulse(1'b0, 8'd0);
    m_start(0);
    send_m(6'h23, 5'd16, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 1'b0);
    chk("lw_wdata", 64'(mem_wdata), 64'h8E080004);
    send_m(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'hFFFF, 1'b1);
    chk("addi_addr", 64'(mem_addr), 64'd4);
    chk("addi_wdata", 64'(mem_wdata), 64'h2022FFFF);
    @(negedge clk);
    @(negedge clk);
    chk("addi_done", 64'(done), 64'd1);
    chk("addi_idle_ready", 64'(in_ready), 64'd0);
    chk("addi_idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("addi_done_drop", 64'(done), 64'd0);
    session_end("itype", d0);

    // Illegal opcodes followed by a legal BEQ
    d0 = done_cnt;
    start_pulse(1'b0, 8'd0);
    m_start(0);
    send_m(6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 1'b0);
    send_m(6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 1'b0);
    chk("ill_eflag", 64'(err_flag), 64'd1);
    chk("ill_eop", 64'(err_op), 64'h02);
    chk("ill_ecount", 64'(err_count), 64'd2);
    chk("ill_nowrite", 64'(obs_q.size()), 64'd0);
    send_m(6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0003, 1'b1);
    chk("beq_wdata", 64'(mem_wdata), 64'h10220003);
    session_end("illegal", d0);

    // start while WRITE and ACCEPT must not move the pointer
    d0 = done_cnt;
    start_pulse(1'b0, 8'd10);
    m_start(10);
    send_m(6'h0C, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00, 16'h1234, 1'b0);
    start_pulse(1'b0, 8'd50);
    start_pulse(1'b0, 8'd60);
    send_m(6'h0D, 5'd5, 5'd6, 5'd0, 5'd0, 6'h00, 16'hABCD, 1'b1);
    chk("ign_addr", 64'(mem_addr), 64'd44);
    session_end("ignore_start", d0);

    // Saturation of the illegal counter
    d0 = done_cnt;
    start_pulse(1'b0, 8'd0);
    m_start(0);
    for (int i = 0; i < 300; i++) begin
      if (i == 0) o = 6'h3F;
      else do o = 6'($urandom_range(0, 63)); while (is_legal(o));
      send_m(o, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, i == 299);
    end
    chk("sat_ecount", 64'(err_count), 64'd255);
    chk("sat_eop", 64'(err_op), 64'h3F);
    session_end("saturate", d0);

    // Randomized sessions
    for (int sidx = 0; sidx < 6; sidx++) begin
      int b;
      b = $urandom_range(0, 200);
      d0 = done_cnt;
      start_pulse(1'b0, 8'(b));
      m_start(b);
      for (int i = 0; i < 20; i++) begin
        if ($urandom_range(0, 3) == 0) o = 6'($urandom_range(0, 63));
        else o = legal_ops[$urandom_range(0, 8)];
        send_m(o, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               6'($urandom_range(0, 63)), 16'($urandom), i == 19);
      end
      session_end("rand", d0);
    end

    // Reset during the WRITE cycle
    start_pulse(1'b0, 8'd0);
    send(1'b0, 6'h23, 5'd7, 5'd9, 5'd0, 5'd0, 6'h00, 16'h00F0, 1'b0, ok);
    chk("mwr_we_before", 64'(mem_we), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("mwr_we_async", 64'(mem_we), 64'd0);
    chk("mwr_wdata", 64'(mem_wdata), 64'd0);
    chk("mwr_addr", 64'(mem_addr), 64'd0);
    chk("mwr_wcount", 64'(word_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mwr_ready", 64'(in_ready), 64'd0);
    chk("mwr_busy", 64'(busy), 64'd0);
    chk("mwr_done", 64'(done), 64'd0);
    chk("mwr_eflag", 64'(err_flag), 64'd0);
    obs_q.delete();

    // Fill a 4-word memory with 5 instructions
    d0 = done2_cnt;
    obs2_q.delete();
    start_pulse(1'b1, 8'd0);
    for (int i = 0; i < 5; i++) begin
      s = 5'($urandom_range(0, 31));
      t = 5'($urandom_range(0, 31));
      im = 16'($urandom);
      send(1'b1, 6'h0D, s, t, 5'd0, 5'd0, 6'h00, im, 1'b0, ok);
      chk("fill_hs", 64'(ok), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) exp2_q.push_back({10'(i * 4), model_word(6'h0D, s, t, 5'd0, 5'd0, 6'h00, im)});
    end
    chk("fill_nwrites", 64'(obs2_q.size()), 64'd4);
    while (exp2_q.size() > 0 && obs2_q.size() > 0)
      chk("fill_write", 64'(obs2_q.pop_front()), 64'(exp2_q.pop_front()));
    chk("fill_full", 64'(full2), 64'd1);
    chk("fill_done", 64'(done2_cnt), 64'(d0 + 1));
    chk("fill_ready", 64'(in_ready2), 64'd0);
    chk("fill_busy", 64'(busy2), 64'd0);
    chk("fill_wcount", 64'(word_count2), 64'd4);
    start_pulse(1'b1, 8'd0);
    chk("refill_full", 64'(full2), 64'd0);
    chk("refill_ready", 64'(in_ready2), 64'd1);
    chk("refill_wcount", 64'(word_count2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
